// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32 core: steps the shared ALU, memory port and
// IR/PC registers through fetch, decode, execute, memory and writeback.
module multicycle_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       instr_retired_o,
  output logic       illegal_instr_o
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBeq      = 4'd10,
    StJal      = 4'd11,
    StHalt     = 4'd12
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    mem_req_o       = 1'b0;
    mem_write_o     = 1'b0;
    adr_src_o       = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    result_src_o    = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    instr_retired_o = 1'b0;
    illegal_instr_o = 1'b0;

    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        // PC+4 goes straight to PC on the same cycle the instruction arrives
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = opcode_i[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        result_src_o    = 2'b01;
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = StFetch;
      end
      StMemWrite: begin
        mem_req_o       = 1'b1;
        mem_write_o     = 1'b1;
        adr_src_o       = 1'b1;
        instr_retired_o = mem_ready_i;
        if (mem_ready_i) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_d     = StAluWb;
      end
      StExecI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = StFetch;
      end
      StBeq: begin
        alu_src_a_o     = 2'b10;
        alu_op_o        = 2'b01;
        pc_write_o      = zero_i;
        instr_retired_o = 1'b1;
        state_d         = StFetch;
      end
      StJal: begin
        // Target computed in decode sits in ALUOut; OldPC+4 is formed here for the link
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = StAluWb;
      end
      StHalt: illegal_instr_o = 1'b1;
      default: state_d = StReset;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for the multicycle control FSM: one vector per clock cycle,
// plus hand sequences for halt persistence and asynchronous reset mid-access.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_retired, illegal_instr;
  logic [15:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, instr_retired, illegal_instr}
  localparam logic [15:0] E_RESET   = 16'h0000;
  localparam logic [15:0] E_FETCHW  = 16'h8220;
  localparam logic [15:0] E_FETCH   = 16'h9A20;
  localparam logic [15:0] E_DECODE  = 16'h0050;
  localparam logic [15:0] E_MEMADR  = 16'h0090;
  localparam logic [15:0] E_MEMREAD = 16'hA000;
  localparam logic [15:0] E_MEMWB   = 16'h0502;
  localparam logic [15:0] E_MEMWRW  = 16'hE000;
  localparam logic [15:0] E_MEMWR   = 16'hE002;
  localparam logic [15:0] E_EXECR   = 16'h0088;
  localparam logic [15:0] E_EXECI   = 16'h0098;
  localparam logic [15:0] E_ALUWB   = 16'h0402;
  localparam logic [15:0] E_BEQT    = 16'h0886;
  localparam logic [15:0] E_BEQN    = 16'h0086;
  localparam logic [15:0] E_JAL     = 16'h0860;
  localparam logic [15:0] E_HALT    = 16'h0001;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  multicycle_controller dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .opcode_i        (opcode),
    .zero_i          (zero),
    .mem_ready_i     (mem_ready),
    .mem_req_o       (mem_req),
    .mem_write_o     (mem_write),
    .adr_src_o       (adr_src),
    .ir_write_o      (ir_write),
    .pc_write_o      (pc_write),
    .reg_write_o     (reg_write),
    .result_src_o    (result_src),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .instr_retired_o (instr_retired),
    .illegal_instr_o (illegal_instr)
  );

  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_op, instr_retired, illegal_instr};

  always #5 clk = ~clk;

  task automatic add(input string name, input logic [6:0] opc, input logic z,
                     input logic rdy, input logic [15:0] exp);
    vec_t v;
    v.name = name;
    v.opc  = opc;
    v.zero = z;
    v.rdy  = rdy;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive inputs just after a rising edge, compare at the falling edge, advance one cycle.
  task automatic step(input string name, input logic [6:0] opc, input logic z,
                      input logic rdy, input logic [15:0] exp);
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    @(negedge clk);
    check(name, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = BAD;
    zero      = 1'b0;
    mem_ready = 1'b0;

    add("reset_state",   BAD, 0, 1, E_RESET);
    add("fetch_wait0",   LW,  0, 0, E_FETCHW);
    add("fetch_wait1",   LW,  0, 0, E_FETCHW);
    add("fetch_wait2",   LW,  0, 0, E_FETCHW);
    add("fetch_ready",   LW,  0, 1, E_FETCH);
    add("lw_decode",     LW,  0, 1, E_DECODE);
    add("lw_memadr",     LW,  0, 1, E_MEMADR);
    add("lw_memread",    LW,  0, 1, E_MEMREAD);
    add("lw_memwb",      LW,  0, 1, E_MEMWB);
    add("sw_fetch",      SW,  0, 1, E_FETCH);
    add("sw_decode",     SW,  0, 1, E_DECODE);
    add("sw_memadr",     SW,  0, 1, E_MEMADR);
    add("sw_write_wait", SW,  0, 0, E_MEMWRW);
    add("sw_write",      SW,  0, 1, E_MEMWR);
    add("r_fetch",       RT,  0, 1, E_FETCH);
    add("r_decode",      RT,  0, 1, E_DECODE);
    add("r_exec",        RT,  0, 1, E_EXECR);
    add("r_aluwb",       RT,  0, 1, E_ALUWB);
    add("i_fetch",       IT,  0, 1, E_FETCH);
    add("i_decode",      IT,  0, 1, E_DECODE);
    add("i_exec",        IT,  0, 1, E_EXECI);
    add("i_aluwb",       IT,  0, 1, E_ALUWB);
    add("beq_t_fetch",   BEQ, 1, 1, E_FETCH);
    add("beq_t_decode",  BEQ, 1, 1, E_DECODE);
    add("beq_taken",     BEQ, 1, 1, E_BEQT);
    add("beq_n_fetch",   BEQ, 0, 1, E_FETCH);
    add("beq_n_decode",  BEQ, 0, 1, E_DECODE);
    add("beq_not_taken", BEQ, 0, 1, E_BEQN);
    add("jal_fetch",     JAL, 0, 1, E_FETCH);
    add("jal_decode",    JAL, 0, 1, E_DECODE);
    add("jal_exec",      JAL, 0, 1, E_JAL);
    add("jal_aluwb",     JAL, 0, 1, E_ALUWB);
    add("lw2_fetch",     LW,  0, 1, E_FETCH);
    add("lw2_decode",    LW,  0, 1, E_DECODE);
    add("lw2_memadr",    LW,  0, 1, E_MEMADR);
    add("lw2_read_wait", LW,  0, 0, E_MEMREAD);
    add("lw2_memread",   LW,  0, 1, E_MEMREAD);
    add("lw2_memwb",     LW,  0, 1, E_MEMWB);
    add("bad_fetch",     BAD, 0, 1, E_FETCH);
    add("bad_decode",    BAD, 0, 1, E_DECODE);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].opc, vecs[i].zero, vecs[i].rdy, vecs[i].exp);

    // Halt is sticky for 10 cycles whatever the inputs do
    for (int i = 0; i < 10; i++) step("halt_hold", BAD, i[0], 1'b1, E_HALT);

    // Asynchronous reset clears the halt without waiting for a clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("halt_async_reset", outs, E_RESET);
    @(posedge clk);
    #1;
    rst = 1'b0;

    step("re_reset",      LW, 0, 1, E_RESET);
    step("re_fetch",      LW, 0, 1, E_FETCH);
    step("re_decode",     LW, 0, 1, E_DECODE);
    step("re_memadr",     LW, 0, 1, E_MEMADR);
    step("re_read_wait",  LW, 0, 0, E_MEMREAD);

    // Reset in the middle of a pending load: request drops at once, nothing retires
    #2;
    rst = 1'b1;
    #1;
    check("midaccess_reset", outs, E_RESET);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held_ready", outs, E_RESET);
    rst = 1'b0;
    step("post_reset",    LW, 0, 1, E_RESET);
    step("post_fetch",    LW, 0, 1, E_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
